// File: rtl/udivider.sv
// -----------------------------------------------------------------------------
// udivider : sequential unsigned restoring divider
//
// Computes Q = A / B and R = A % B, producing one quotient bit per clock.
// Companion of the shift-add unsigned multiplier; same start/busy/valid
// handshake so the two can be swapped behind the same control logic.
//
// Parameters
//   WIDTH      bit width of A, B, Q and R (>= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (wins over start)
//   start      load A/B and begin a division; sampled every rising edge
//   A, B       dividend / divisor, sampled only on the edge where start=1
//   Q, R       quotient / remainder registers; hold the last result
//   valid_out  Q/R/dbz_out hold a completed result
//   busy_out   division in progress
//   dbz_out    last completed division had B == 0
//
// Optional build macro
//   UDIVIDER_DEBUG_EN  adds i_out, rem_out, quot_out, state_out, which expose
//                      the live iteration counter, partial remainder,
//                      quotient shifter and FSM state. Behaviour and timing
//                      are identical with or without the macro.
//
// Handshake: a start sampled high on any edge (any state) loads the operands,
// drops valid_out and raises busy_out, aborting any division in flight. The
// result appears WIDTH+1 edges later: busy_out falls and valid_out rises on
// the same edge, and valid_out then stays high with Q/R/dbz_out stable until
// the next start or reset. There is no back-pressure; a result is never lost
// because it is held until the caller starts another division.
// -----------------------------------------------------------------------------
module udivider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             valid_out,
  output logic             busy_out,
  output logic             dbz_out
`ifdef UDIVIDER_DEBUG_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] i_out,
  output logic [WIDTH:0]             rem_out,
  output logic [WIDTH-1:0]           quot_out,
  output logic [1:0]                 state_out
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  // Restored partial remainder. It is always strictly below the divisor, so
  // it fits in WIDTH bits; the extra bit only exists in the trial subtraction.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;   // holds the dividend, fills with quotient bits
  logic [WIDTH-1:0] r_div;    // divisor latched at start
  logic [CW-1:0]    r_i;      // number of quotient bits produced so far
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_valid;
  logic             r_busy;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quot_next;
  logic             w_step_en;
  logic             w_done;

  // ---------------------------------------------------------------------------
  // One restoring step: shift the next dividend bit into the remainder, try a
  // subtraction, and keep it only if it did not go negative.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_shift     = {r_rem, r_quot[WIDTH-1]};
    w_trial     = w_shift - {1'b0, r_div};
    w_rem_next  = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_quot_next = {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath enables. start has priority in every state.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_step_en    = 1'b0;
    w_done       = 1'b0;
    if (start) begin
      w_next_state = S_RUN;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next_state = S_IDLE;
        end
        S_RUN: begin
          w_step_en = 1'b1;
          // The step taken from i == WIDTH-1 produces the last quotient bit,
          // so the FSM sits in DONE with i == WIDTH for one cycle.
          if (r_i == CW'(WIDTH - 1)) begin
            w_next_state = S_DONE;
          end
        end
        S_DONE: begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers. Q/R only change on the DONE edge so that
  // intermediate quotient/remainder values never appear on the outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_quot  <= '0;
      r_div   <= '0;
      r_i     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_dbz   <= 1'b0;
    end else if (start) begin
      r_rem   <= '0;
      r_quot  <= A;
      r_div   <= B;
      r_i     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
      r_dbz   <= 1'b0;
    end else if (w_step_en) begin
      r_rem   <= w_rem_next;
      r_quot  <= w_quot_next;
      r_i     <= r_i + CW'(1);
    end else if (w_done) begin
      // A zero divisor needs no special path: every trial subtraction
      // succeeds, leaving Q all ones and R equal to A.
      r_q     <= r_quot;
      r_r     <= r_rem;
      r_dbz   <= (r_div == '0);
      r_valid <= 1'b1;
      r_busy  <= 1'b0;
    end
  end

  assign Q         = r_q;
  assign R         = r_r;
  assign valid_out = r_valid;
  assign busy_out  = r_busy;
  assign dbz_out   = r_dbz;

`ifdef UDIVIDER_DEBUG_EN
  assign i_out     = r_i;
  assign rem_out   = {1'b0, r_rem};
  assign quot_out  = r_quot;
  assign state_out = r_state;
`endif

endmodule

// File: tb/tb_udivider.sv
// -----------------------------------------------------------------------------
// tb_udivider : directed scoreboard bench for udivider
//
// Two instances: WIDTH=4 (main directed scenarios) and WIDTH=8 (wider
// vectors incl. 255/16). Drivers push the hand-computed result into an
// expected queue before pulsing start; a monitor per instance pops and
// compares whenever valid_out rises.
// -----------------------------------------------------------------------------
module tb_udivider;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- WIDTH=4 DUT
  logic       start;
  logic [3:0] a_in, b_in, q_out, r_out;
  logic       valid_out, busy_out, dbz_out;

  // ---------------------------------------------------------------- WIDTH=8 DUT
  logic       start8;
  logic [7:0] a8, b8, q8, r8;
  logic       valid8, busy8, dbz8;

`ifdef UDIVIDER_DEBUG_EN
  logic [2:0] i_out4;
  logic [4:0] rem_out4;
  logic [3:0] quot_out4;
  logic [1:0] state_out4;
  logic [3:0] i_out8;
  logic [8:0] rem_out8;
  logic [7:0] quot_out8;
  logic [1:0] state_out8;
`endif

  udivider #(.WIDTH(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (a_in),
    .B         (b_in),
    .Q         (q_out),
    .R         (r_out),
    .valid_out (valid_out),
    .busy_out  (busy_out),
    .dbz_out   (dbz_out)
`ifdef UDIVIDER_DEBUG_EN
    ,
    .i_out     (i_out4),
    .rem_out   (rem_out4),
    .quot_out  (quot_out4),
    .state_out (state_out4)
`endif
  );

  udivider #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start8),
    .A         (a8),
    .B         (b8),
    .Q         (q8),
    .R         (r8),
    .valid_out (valid8),
    .busy_out  (busy8),
    .dbz_out   (dbz8)
`ifdef UDIVIDER_DEBUG_EN
    ,
    .i_out     (i_out8),
    .rem_out   (rem_out8),
    .quot_out  (quot_out8),
    .state_out (state_out8)
`endif
  );

  // ---------------------------------------------------------------- scoreboard
  logic [8:0]  exp_q[$];    // {dbz, Q, R} for WIDTH=4
  logic [16:0] exp8_q[$];   // {dbz, Q, R} for WIDTH=8
  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] last_q = '0;  // result the WIDTH=4 outputs must hold while busy
  logic [3:0] last_r = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor, WIDTH=4
  initial begin
    logic prev_v;
    logic [8:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (valid_out && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("w4_unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("w4_Q",   {28'd0, q_out}, {28'd0, e[7:4]});
          check("w4_R",   {28'd0, r_out}, {28'd0, e[3:0]});
          check("w4_dbz", {31'd0, dbz_out}, {31'd0, e[8]});
        end
      end
      prev_v = valid_out;
    end
  end

  // Monitor, WIDTH=8
  initial begin
    logic prev_v;
    logic [16:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (valid8 && !prev_v) begin
        if (exp8_q.size() == 0) begin
          check("w8_unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp8_q.pop_front();
          check("w8_Q",   {24'd0, q8}, {24'd0, e[15:8]});
          check("w8_R",   {24'd0, r8}, {24'd0, e[7:0]});
          check("w8_dbz", {31'd0, dbz8}, {31'd0, e[16]});
        end
      end
      prev_v = valid8;
    end
  end

  // ---------------------------------------------------------------- drivers
  // Called at a negedge: start is sampled on the following posedge (edge 0),
  // then operands are scrambled since only the start-edge sample matters.
  task automatic pulse_start(input logic [3:0] a, input logic [3:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = 4'($urandom_range(0, 15));
    b_in  = 4'($urandom_range(0, 15));
    check("w4_busy_after_start",  {31'd0, busy_out},  32'd1);
    check("w4_valid_after_start", {31'd0, valid_out}, 32'd0);
  endtask

  // Waits for valid; result must appear WIDTH+1 edges after the start edge
  // and Q/R must keep the previous result throughout the run.
  task automatic wait_valid4();
    int cycles;
    cycles = 0;
    while (!valid_out && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (busy_out) check("w4_hold_QR", {24'd0, q_out, r_out}, {24'd0, last_q, last_r});
    end
    check("w4_latency", cycles, 32'd5);
    check("w4_busy_after_done", {31'd0, busy_out}, 32'd0);
  endtask

  task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] q, input logic [3:0] r, input logic dbz);
    exp_q.push_back({dbz, q, r});
    pulse_start(a, b);
    wait_valid4();
    last_q = q;
    last_r = r;
  endtask

  task automatic run_div8(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] q, input logic [7:0] r, input logic dbz);
    int cycles;
    exp8_q.push_back({dbz, q, r});
    a8     = a;
    b8     = b;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8     = 8'($urandom_range(0, 255));
    b8     = 8'($urandom_range(0, 255));
    cycles = 0;
`ifdef UDIVIDER_DEBUG_EN
    check("w8_i_out", {28'd0, i_out8}, 32'd0);
`endif
    while (!valid8 && cycles < 60) begin
      @(negedge clk);
      cycles++;
`ifdef UDIVIDER_DEBUG_EN
      if (busy8) check("w8_i_out", {28'd0, i_out8}, cycles);
`endif
    end
    check("w8_latency", cycles, 32'd9);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main
  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start8 = 1'b0;
    a_in   = '0;
    b_in   = '0;
    a8     = '0;
    b8     = '0;
    repeat (3) @(negedge clk);
    check("reset_Q",     {28'd0, q_out},      32'd0);
    check("reset_R",     {28'd0, r_out},      32'd0);
    check("reset_valid", {31'd0, valid_out},  32'd0);
    check("reset_busy",  {31'd0, busy_out},   32'd0);
    check("reset_dbz",   {31'd0, dbz_out},    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic division
    run_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);

    // Corner patterns, valid held until next start
    run_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("valid_held", {31'd0, valid_out}, 32'd1);
    check("Q_held",     {28'd0, q_out},     32'd15);
    check("R_held",     {28'd0, r_out},     32'd0);
    run_div(4'd2,  4'd9, 4'd0, 4'd2, 1'b0);
    run_div(4'd0,  4'd5, 4'd0, 4'd0, 1'b0);
    run_div(4'd4,  4'd4, 4'd1, 4'd0, 1'b0);

    // Divide by zero, then a normal run clears dbz
    run_div(4'd7,  4'd0, 4'd15, 4'd7, 1'b1);
    run_div(4'd6,  4'd2, 4'd3,  4'd0, 1'b0);

    // Restart while busy: only the second division produces a result
    pulse_start(4'd13, 4'd3);
    @(negedge clk);
    run_div(4'd9,  4'd4, 4'd2,  4'd1, 1'b0);

    // Reset mid-division
    pulse_start(4'd13, 4'd3);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_Q",     {28'd0, q_out},     32'd0);
    check("midrst_R",     {28'd0, r_out},     32'd0);
    check("midrst_valid", {31'd0, valid_out}, 32'd0);
    check("midrst_busy",  {31'd0, busy_out},  32'd0);
    check("midrst_dbz",   {31'd0, dbz_out},   32'd0);
    rst_n  = 1'b1;
    last_q = '0;
    last_r = '0;
    repeat (8) @(negedge clk);
    check("midrst_no_valid", {31'd0, valid_out}, 32'd0);

    // Reset and start together: reset wins
    rst_n = 1'b0;
    start = 1'b1;
    a_in  = 4'd5;
    b_in  = 4'd1;
    @(negedge clk);
    check("rst_vs_start_busy",  {31'd0, busy_out},  32'd0);
    check("rst_vs_start_valid", {31'd0, valid_out}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_vs_start_idle", {31'd0, busy_out}, 32'd0);

    // A run after the reset still works
    run_div(4'd11, 4'd2, 4'd5, 4'd1, 1'b0);

    // WIDTH=8 vectors
    run_div8(8'd255, 8'd16,  8'd15,  8'd15,  1'b0);
    run_div8(8'd200, 8'd7,   8'd28,  8'd4,   1'b0);
    run_div8(8'd100, 8'd0,   8'd255, 8'd100, 1'b1);
    run_div8(8'd17,  8'd200, 8'd0,   8'd17,  1'b0);
    run_div8(8'd255, 8'd1,   8'd255, 8'd0,   1'b0);
    run_div8(8'd128, 8'd3,   8'd42,  8'd2,   1'b0);

    repeat (4) @(negedge clk);
    check("w4_queue_drained", exp_q.size(),  32'd0);
    check("w8_queue_drained", exp8_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
